sa_output_deskew: RTL and testbench



---
 rtl/sa_pkg.sv | 16 +
 rtl/sa_sync_fifo.sv | 58 +++++
 rtl/sa_output_deskew.sv | 118 +++++++++++
 tb/tb_sa_output_deskew.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and default dimensions for the systolic-array drain path.
package sa_pkg;

  localparam int SIZE_DEF      = 16;
  localparam int ACC_WIDTH_DEF = 16;
  localparam int TAG_WIDTH     = 16;

  typedef logic [ACC_WIDTH_DEF-1:0] acc_t;
  typedef logic [TAG_WIDTH-1:0]     tag_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with indexed head read; a push into a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module sa_sync_fifo
  import sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [WIDTH-1:0]            i_data,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_wr;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop = i_pop & ~o_empty;
  assign w_wr  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sa_output_deskew.sv
// Realigns skewed bottom-row accumulations into whole vectors and buffers them.
// Optional SA_DESKEW_ROW_TAG_EN adds a 16-bit row tag carried with each vector.
module sa_output_deskew
  import sa_pkg::*;
#(
  parameter int SIZE      = SIZE_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [SIZE-1:0][ACC_WIDTH-1:0]   acc_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0][ACC_WIDTH-1:0]   out_data,
  output logic [cnt_width(DEPTH)-1:0]      fifo_count,
  output logic                             overflow_err,
  input  logic                             clear_err
`ifdef SA_DESKEW_ROW_TAG_EN
  ,
  output tag_t                             out_tag
`endif
);

  localparam int DW_VEC = SIZE * ACC_WIDTH;
`ifdef SA_DESKEW_ROW_TAG_EN
  localparam int DW = DW_VEC + TAG_WIDTH;
`else
  localparam int DW = DW_VEC;
`endif

  logic [SIZE-1:0][ACC_WIDTH-1:0] w_aligned;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_drop;
  logic [DW-1:0]                  w_wdata;
  logic [DW-1:0]                  w_rdata;

  // Column j arrives j cycles late, so it needs SIZE-1-j stages to meet the last column.
  genvar j;
  for (j = 0; j < SIZE; j++) begin : g_col
    if (j == SIZE-1) begin : g_direct
      assign w_aligned[j] = acc_in[j];
    end else begin : g_dly
      localparam int L = SIZE - 1 - j;
      logic [ACC_WIDTH-1:0] r_sh [L];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < L; k++) r_sh[k] <= '0;
        end else begin
          r_sh[0] <= acc_in[j];
          for (int k = 1; k < L; k++) r_sh[k] <= r_sh[k-1];
        end
      end
      assign w_aligned[j] = r_sh[L-1];
    end
  end

  if (SIZE > 1) begin : g_vpipe
    logic [SIZE-2:0] r_vpipe;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe[0] <= in_valid;
        for (int k = 1; k < SIZE-1; k++) r_vpipe[k] <= r_vpipe[k-1];
      end
    end
    assign w_push = r_vpipe[SIZE-2];
  end else begin : g_novpipe
    assign w_push = in_valid;
  end

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = w_push & w_full & ~w_pop;

`ifdef SA_DESKEW_ROW_TAG_EN
  tag_t r_row_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_row_tag <= '0;
    else if (w_push & ~w_drop) r_row_tag <= r_row_tag + 1'b1;
  end

  assign w_wdata  = {r_row_tag, w_aligned};
  assign out_tag  = w_rdata[DW-1 -: TAG_WIDTH];
`else
  assign w_wdata  = w_aligned;
`endif
  assign out_data = w_rdata[DW_VEC-1:0];

  sa_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wdata),
    .o_data  (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // A drop in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow_err <= 1'b0;
    else if (w_drop)    overflow_err <= 1'b1;
    else if (clear_err) overflow_err <= 1'b0;
  end

endmodule

// File: tb/tb_sa_output_deskew.sv
// Bench for sa_output_deskew (SIZE=4, DEPTH=2): directed scenarios plus random
// traffic against a queue-based reference model.
module tb_sa_output_deskew;
  import sa_pkg::*;

  localparam int S    = 4;
  localparam int W    = 16;
  localparam int D    = 2;
  localparam int MAXC = 4096;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [S-1:0][W-1:0]  acc_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [S-1:0][W-1:0]  out_data;
  logic [1:0]           fifo_count;
  logic                 overflow_err;
  logic                 clear_err;
`ifdef SA_DESKEW_ROW_TAG_EN
  tag_t                 out_tag;
`endif

  always #5 clk = ~clk;

  sa_output_deskew #(.SIZE(S), .ACC_WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .acc_in       (acc_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .clear_err    (clear_err)
`ifdef SA_DESKEW_ROW_TAG_EN
    ,
    .out_tag      (out_tag)
`endif
  );

  typedef struct {
    logic [S*W-1:0] d;
    logic [15:0]    tag;
  } ent_t;

  int             n_chk = 0;
  int             n_pass = 0;
  int             c = 0;
  bit             inj [MAXC];
  logic [W-1:0]   vals [MAXC][S];
  ent_t           q [$];
  bit             m_err = 1'b0;
  logic [15:0]    m_tag = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
  endtask

  // One clock cycle: check state left by the previous edge, drive inputs,
  // advance the model across the coming edge, then move to the next negedge.
  task automatic step(input bit iv, input logic [S*W-1:0] v, input bit rdy, input bit clr);
    bit             pop, push, full;
    logic [S*W-1:0] vec;
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("fifo_count", {62'd0, fifo_count}, 64'(q.size()));
    chk("overflow_err", {63'd0, overflow_err}, {63'd0, m_err});
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
`ifdef SA_DESKEW_ROW_TAG_EN
      chk("out_tag", {48'd0, out_tag}, {48'd0, q[0].tag});
`endif
    end
    in_valid = iv;
    inj[c]   = iv;
    for (int j = 0; j < S; j++) vals[c][j] = v[j*W +: W];
    for (int j = 0; j < S; j++) begin
      if (c >= j && inj[c-j]) acc_in[j] = vals[c-j][j];
      else                    acc_in[j] = 16'($urandom);
    end
    out_ready = rdy;
    clear_err = clr;
    full = (q.size() == D);
    pop  = (q.size() != 0) && rdy;
    push = (c >= S-1) && inj[c-(S-1)];
    vec  = '0;
    if (push) for (int j = 0; j < S; j++) vec[j*W +: W] = vals[c-(S-1)][j];
    if (pop) void'(q.pop_front());
    if (push && full && !pop) begin
      m_err = 1'b1;
    end else begin
      if (push) begin
        q.push_back('{d: vec, tag: m_tag});
        m_tag++;
      end
      if (clr) m_err = 1'b0;
    end
    @(negedge clk);
    c++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fifo_count", {62'd0, fifo_count}, 64'd0);
    chk("rst_overflow", {63'd0, overflow_err}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < c; k++) inj[k] = 1'b0;
    q.delete();
    m_err = 1'b0;
    m_tag = '0;
  endtask

  logic [S*W-1:0] rv;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    acc_in    = '0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pulse_reset();

    // single row: aligned vector visible four cycles after in_valid
    step(1'b1, {16'h13, 16'h12, 16'h11, 16'h10}, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_data", out_data, 64'h0013_0012_0011_0010);
    chk("single_count", {62'd0, fifo_count}, 64'd1);
    idle(2, 1'b1);

    // stall fill
    step(1'b1, {16'hA3, 16'hA2, 16'hA1, 16'hA0}, 1'b0, 1'b0);
    step(1'b1, {16'hB3, 16'hB2, 16'hB1, 16'hB0}, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("fill_count", {62'd0, fifo_count}, 64'd2);
    chk("fill_head", out_data, 64'h00A3_00A2_00A1_00A0);
    idle(1, 1'b1);
    chk("fill_next", out_data, 64'h00B3_00B2_00B1_00B0);
    chk("fill_noerr", {63'd0, overflow_err}, 64'd0);
    idle(2, 1'b1);

    // overflow, then full FIFO with simultaneous push and pop
    pulse_reset();
    step(1'b1, {16'hA3, 16'hA2, 16'hA1, 16'hA0}, 1'b0, 1'b0);
    step(1'b1, {16'hB3, 16'hB2, 16'hB1, 16'hB0}, 1'b0, 1'b0);
    step(1'b1, {16'hC3, 16'hC2, 16'hC1, 16'hC0}, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("ovf_err", {63'd0, overflow_err}, 64'd1);
    chk("ovf_head", out_data, 64'h00A3_00A2_00A1_00A0);
    chk("ovf_count", {62'd0, fifo_count}, 64'd2);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clear", {63'd0, overflow_err}, 64'd0);
    step(1'b1, {16'hD3, 16'hD2, 16'hD1, 16'hD0}, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    chk("pp_count", {62'd0, fifo_count}, 64'd2);
    chk("pp_noerr", {63'd0, overflow_err}, 64'd0);
    chk("pp_head", out_data, 64'h00B3_00B2_00B1_00B0);
`ifdef SA_DESKEW_ROW_TAG_EN
    chk("tag_b", {48'd0, out_tag}, 64'd1);
    idle(1, 1'b1);
    chk("tag_d", {48'd0, out_tag}, 64'd2);
`endif
    idle(3, 1'b1);

    // reset while a row is in flight
    step(1'b1, {16'hE3, 16'hE2, 16'hE1, 16'hE0}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    pulse_reset();
    idle(10, 1'b0);
    chk("rstmid_quiet", {63'd0, out_valid}, 64'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rv = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step(($urandom_range(0, 2) != 0), rv, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0);
    end
    idle(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
